// File: rtl/mathrix_pkg.sv
// mathrix_pkg: shared operator encodings, round states and defaults
package mathrix_pkg;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam int DEFAULT_MAX_TRIES = 3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_WAIT_GO,
    S_CHECK,
    S_DONE
  } round_state_t;
endpackage

// File: rtl/go_edge_sync.sv
// go_edge_sync: two-flop synchronizer plus rising-edge detector for a raw key
module go_edge_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic Din,
  output logic Rise
);
  logic meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
  // shift the raw key through the synchronizer and keep one cycle of history
  always_comb begin
    meta_d = Din;
    sync_d = meta_q;
    prev_d = sync_q;
  end
  // synchronizer and history registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign Rise = sync_q & ~prev_q;
endmodule

// File: rtl/equation_round.sv
// equation_round: one math-problem round - derive operands, grade answers, report result
module equation_round
  import mathrix_pkg::*;
#(
  parameter int MAX_TRIES = DEFAULT_MAX_TRIES
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [6:0] Seed,
  input  logic       Go,
  input  logic [7:0] DataIn,
  output logic [3:0] OperandA,
  output logic [3:0] OperandB,
  output logic [1:0] Op,
  output logic       Show,
  output logic       Correct,
  output logic       Done,
  output logic       Wrong,
  output logic [1:0] Tries
);
  localparam logic [1:0] MAX_T = 2'(MAX_TRIES);
  round_state_t state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d, tries_q, tries_d;
  logic [7:0] expected_q, expected_d, answer_q, answer_d;
  logic wrong_q, wrong_d, correct_q, correct_d, done_q, done_d;
  logic go_rise;
  go_edge_sync u_go (
    .Clock(Clock),
    .Reset(Reset),
    .Din  (Go),
    .Rise (go_rise)
  );
  function automatic logic [7:0] calc_expected(logic [3:0] a, logic [3:0] b, logic [1:0] op);
    logic [7:0] wa, wb;
    wa = {4'd0, a};
    wb = {4'd0, b};
    return op == OP_MUL ? wa * wb : op == OP_SUB ? (wa > wb ? wa - wb : wb - wa) : wa + wb;
  endfunction
  // next-state and datapath updates; abort on Start low wins over any Go edge or grade
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    expected_d = expected_q;
    answer_d   = answer_q;
    wrong_d    = wrong_q;
    tries_d    = tries_q;
    correct_d  = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: state_d = Start ? S_LATCH : S_IDLE;
      S_LATCH:
        if (!Start) state_d = S_IDLE;
        else begin
          a_d        = Seed[6:3];
          b_d        = Seed[3:0];
          op_d       = Seed[1:0];
          expected_d = calc_expected(Seed[6:3], Seed[3:0], Seed[1:0]);
          wrong_d    = 1'b0;
          tries_d    = 2'd0;
          state_d    = S_WAIT_GO;
        end
      S_WAIT_GO:
        if (!Start) state_d = S_IDLE;
        else if (go_rise) begin
          answer_d = DataIn;
          state_d  = S_CHECK;
        end
      S_CHECK:
        if (!Start) state_d = S_IDLE;
        else if (answer_q == expected_q) begin
          correct_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          tries_d = tries_q + 2'd1;
          wrong_d = 1'b1;
          done_d  = tries_d == MAX_T;
          state_d = tries_d == MAX_T ? S_DONE : S_WAIT_GO;
        end
      S_DONE: state_d = Start ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // round state, operands, grading registers and result pulses
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      op_q       <= 2'd0;
      expected_q <= 8'd0;
      answer_q   <= 8'd0;
      wrong_q    <= 1'b0;
      tries_q    <= 2'd0;
      correct_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      expected_q <= expected_d;
      answer_q   <= answer_d;
      wrong_q    <= wrong_d;
      tries_q    <= tries_d;
      correct_q  <= correct_d;
      done_q     <= done_d;
    end
  end
  assign OperandA = a_q;
  assign OperandB = b_q;
  assign Op       = op_q;
  assign Show     = state_q == S_WAIT_GO;
  assign Correct  = correct_q;
  assign Done     = done_q;
  assign Wrong    = wrong_q;
  assign Tries    = tries_q;
endmodule

// File: tb/tb_equation_round.sv
// tb_equation_round: directed and random checks of equation_round against a round-level model
module tb_equation_round;
  localparam int MAX_TRIES = 3;
  localparam int P_IDLE = 0, P_LATCH = 1, P_AWAIT = 2, P_GRADE = 3, P_FIN = 4;
  logic       Clock = 1'b0, Reset = 1'b1, Start = 1'b0, Go = 1'b0;
  logic [6:0] Seed = 7'd0;
  logic [7:0] DataIn = 8'd0;
  logic [3:0] OperandA, OperandB;
  logic [1:0] Op, Tries;
  logic       Show, Correct, Done, Wrong;
  int n_checks = 0, n_fail = 0;
  int phase = P_IDLE, ma = 0, mb = 0, mop = 0, mexp = 0, mans = 0, mtries = 0;
  int mwrong = 0, mcorrect = 0, mdone = 0;
  logic [2:0] hist = 3'd0;
  equation_round #(.MAX_TRIES(MAX_TRIES)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Seed(Seed), .Go(Go), .DataIn(DataIn),
    .OperandA(OperandA), .OperandB(OperandB), .Op(Op), .Show(Show), .Correct(Correct),
    .Done(Done), .Wrong(Wrong), .Tries(Tries)
  );
  always #10 Clock = ~Clock;
  function automatic int model_exp(int a, int b, int op);
    if (op == 2) return a * b;
    if (op == 1) return a > b ? a - b : b - a;
    return a + b;
  endfunction
  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic model_step();
    logic rise;
    mcorrect = 0;
    mdone = 0;
    if (Reset) begin
      phase = P_IDLE; ma = 0; mb = 0; mop = 0; mexp = 0; mans = 0;
      mtries = 0; mwrong = 0; hist = 3'd0;
      return;
    end
    rise = hist[1] && !hist[2];
    hist = {hist[1:0], Go};
    if (phase != P_IDLE && phase != P_FIN && !Start) begin
      phase = P_IDLE;
      return;
    end
    if (phase == P_IDLE) begin
      if (Start) phase = P_LATCH;
    end else if (phase == P_LATCH) begin
      ma = int'(Seed[6:3]);
      mb = int'(Seed[3:0]);
      mop = int'(Seed[1:0]);
      mexp = model_exp(ma, mb, mop);
      mwrong = 0;
      mtries = 0;
      phase = P_AWAIT;
    end else if (phase == P_AWAIT) begin
      if (rise) begin
        mans = int'(DataIn);
        phase = P_GRADE;
      end
    end else if (phase == P_GRADE) begin
      if (mans == mexp) begin
        mcorrect = 1;
        mdone = 1;
        phase = P_FIN;
      end else begin
        mtries++;
        mwrong = 1;
        if (mtries == MAX_TRIES) begin
          mdone = 1;
          phase = P_FIN;
        end else phase = P_AWAIT;
      end
    end else if (!Start) phase = P_IDLE;
  endtask
  initial forever begin
    @(posedge Clock or posedge Reset);
    model_step();
  end
  initial forever begin
    @(negedge Clock);
    chk("cmp Show", int'(Show), int'(phase == P_AWAIT));
    chk("cmp Correct", int'(Correct), mcorrect);
    chk("cmp Done", int'(Done), mdone);
    chk("cmp Wrong", int'(Wrong), mwrong);
    chk("cmp Tries", int'(Tries), mtries);
    chk("cmp OperandA", int'(OperandA), ma);
    chk("cmp OperandB", int'(OperandB), mb);
    chk("cmp Op", int'(Op), mop);
  end
  task automatic tick();
    @(negedge Clock);
  endtask
  task automatic press(input logic [7:0] ans, output int c, output int d);
    DataIn = ans;
    Go = 1'b1;
    repeat (3) tick();
    chk("no early Correct", int'(Correct), 0);
    tick();
    c = int'(Correct);
    d = int'(Done);
    Go = 1'b0;
    repeat (3) tick();
  endtask
  task automatic idle_out();
    Start = 1'b0;
    Go = 1'b0;
    repeat (4) tick();
  endtask
  initial begin
    int c, d, cnt;
    repeat (2) tick();
    chk("reset Show", int'(Show), 0);
    chk("reset Tries", int'(Tries), 0);
    chk("reset OperandA", int'(OperandA), 0);
    #2 Reset = 1'b0;
    tick();
    Seed = 7'b0101011;
    Start = 1'b1;
    tick();
    chk("Show after one edge", int'(Show), 0);
    tick();
    chk("t1 Show", int'(Show), 1);
    chk("t1 OperandA", int'(OperandA), 5);
    chk("t1 OperandB", int'(OperandB), 11);
    chk("t1 Op", int'(Op), 3);
    chk("t1 model expected", mexp, 16);
    press(8'd16, c, d);
    chk("t1 Correct", c, 1);
    chk("t1 Done", d, 1);
    chk("t1 Correct cleared", int'(Correct), 0);
    chk("t1 Wrong", int'(Wrong), 0);
    chk("t1 Tries", int'(Tries), 0);
    chk("t1 Show in done", int'(Show), 0);
    idle_out();
    Seed = 7'b0010101;
    Start = 1'b1;
    repeat (2) tick();
    chk("t2 model expected", mexp, 3);
    press(8'd3, c, d);
    chk("t2 Correct", c, 1);
    Start = 1'b0;
    tick();
    chk("t2 Show after abort", int'(Show), 0);
    idle_out();
    Seed = 7'b1111110;
    Start = 1'b1;
    repeat (2) tick();
    chk("t3 model expected", mexp, 210);
    DataIn = 8'd210;
    Go = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      cnt += int'(Correct);
    end
    chk("t3 single Correct on held Go", cnt, 1);
    idle_out();
    Seed = 7'b0101011;
    Start = 1'b1;
    repeat (2) tick();
    press(8'd0, c, d);
    chk("t4 Tries 1", int'(Tries), 1);
    chk("t4 Wrong 1", int'(Wrong), 1);
    chk("t4 Done 1", d, 0);
    press(8'd0, c, d);
    chk("t4 Tries 2", int'(Tries), 2);
    chk("t4 Correct 2", c, 0);
    press(8'd0, c, d);
    chk("t4 Tries 3", int'(Tries), 3);
    chk("t4 Done 3", d, 1);
    chk("t4 Correct 3", c, 0);
    idle_out();
    Start = 1'b1;
    repeat (2) tick();
    DataIn = 8'd16;
    Go = 1'b1;
    repeat (2) tick();
    Start = 1'b0;
    tick();
    chk("t5 Show", int'(Show), 0);
    cnt = 0;
    repeat (3) begin
      cnt += int'(Correct) + int'(Done);
      tick();
    end
    chk("t5 no pulses", cnt, 0);
    idle_out();
    Start = 1'b1;
    repeat (2) tick();
    press(8'd0, c, d);
    DataIn = 8'd16;
    Go = 1'b1;
    repeat (3) tick();
    #2 Reset = 1'b1;
    #1;
    chk("t6 Show", int'(Show), 0);
    chk("t6 Correct", int'(Correct), 0);
    chk("t6 Wrong", int'(Wrong), 0);
    chk("t6 Tries", int'(Tries), 0);
    chk("t6 OperandA", int'(OperandA), 0);
    Go = 1'b0;
    tick();
    #2 Reset = 1'b0;
    repeat (2) tick();
    chk("t6 Show after release", int'(Show), 1);
    chk("t6 OperandB after release", int'(OperandB), 11);
    chk("t6 Tries after release", int'(Tries), 0);
    for (int i = 0; i < 3000; i++) begin
      tick();
      Seed = 7'($urandom);
      if (Start) Start = ($urandom_range(0, 24) != 0);
      else Start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) Go = ~Go;
      DataIn = $urandom_range(0, 1) ? 8'(mexp) : 8'($urandom);
      if (Reset) #2 Reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) #2 Reset = 1'b1;
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/equation_round.md
# equation_round

Runs one math-problem round of the alarm game. It is instantiated once per equation slot and driven by the top control FSM's per-equation start level. It derives operands and an operator from the free-running seed counter and presents them for display. It then accepts switch answers on Go presses, grades each one, and reports a correct/done pulse plus a sticky wrong flag that the top FSM uses to choose between the sequencer and the done state.

## Interface
- MAX_TRIES, 3: wrong answers allowed before the round ends unsolved; legal range 1..3.
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high; clock Clock.
- Start  in  1  level from top FSM; high = round active, low = abort/idle.
- Seed  in  7  free-running counter value, sampled once per round.
- Go  in  1  answer-submit key, active-high, asynchronous to Clock.
- DataIn  in  8  answer switches, unsigned.
- OperandA  out  4  left operand for display.
- OperandB  out  4  right operand for display.
- Op  out  2  operator: 0 add, 1 sub, 2 mul, 3 add.
- Show  out  1  operands valid and answer being awaited.
- Correct  out  1  one-cycle pulse: right answer accepted.
- Done  out  1  one-cycle pulse: round finished (right answer or tries exhausted).
- Wrong  out  1  sticky: at least one wrong answer this round.
- Tries  out  2  count of wrong answers this round.

## Operation
- States: IDLE, LATCH, WAIT_GO, CHECK, DONE.
- IDLE: when Start=1, go to LATCH.
- LATCH (1 cycle):
  - A=Seed[6:3], B=Seed[3:0], Op=Seed[1:0].
  - Expected (8 bit) = A+B for Op 0/3, |A−B| for Op 1 (larger minus smaller), A*B for Op 2. The maximum is 225, so no overflow.
  - Clears Wrong and Tries. Next state is WAIT_GO.
- WAIT_GO: Show=1. A rising edge of the synchronized Go captures DataIn into Answer, then go to CHECK.
- CHECK (1 cycle):
  - Answer==Expected: pulse Correct and Done, go to DONE.
  - Otherwise increment Tries and set Wrong. If Tries+1==MAX_TRIES, pulse Done only and go to DONE; else return to WAIT_GO.
- DONE: Show=0. Operands, Wrong and Tries hold. Return to IDLE when Start=0.
- Start=0 in LATCH, WAIT_GO or CHECK aborts to IDLE on the next edge. No Correct/Done pulse is issued. Abort has priority over a coincident Go edge or grading result.
- Go edges in IDLE, LATCH, CHECK and DONE are ignored. The edge-detector history still updates, so a key held from a previous state does not fire on entry to WAIT_GO.
- Go held high for many cycles counts as exactly one submission. It must go low, then high again, to submit again.

## Timing
- Reset (async): state=IDLE, sync/edge flops=0, every output=0.
- Go path is a 2-flop synchronizer plus previous-value flop. Latency:
  - Edge 1 samples raw Go high; edge 2 makes sync high while prev is low.
  - Edge 3 captures Answer and enters CHECK.
  - Edge 4 sets Correct/Done=1 and enters DONE.
  - Edge 5 clears Correct/Done.
- Start high to Show=1: two edges (IDLE→LATCH→WAIT_GO).
- Correct and Done are registered and high for exactly one cycle. Correct always coincides with Done.
- Wrong and Tries update on the edge leaving CHECK.
- Reset asserted mid-round clears everything immediately with no pulse. After release, the block returns to LATCH only if Start is high.

## Structure
- Shared package mathrix_pkg:
  - op encoding constants (OP_ADD, OP_SUB, OP_MUL).
  - state enum for this block.
  - default MAX_TRIES.
- Sub-module go_edge_sync: 2-flop synchronizer plus rising-edge detector, async reset. It is reused for the other Go/Start keys.
- The expected-value arithmetic stays inline as a combinational function registered in LATCH.

## Test plan
- Seed=7'b0101011 (A=5, B=11, Op=3), Start=1, DataIn=16, Go pulse → Show=1 then Correct=Done=1 for one cycle on the 4th edge after Go; Wrong=0, Tries=0.
- Seed=7'b0010101 (A=2, B=5, sub), DataIn=3, Go → Correct pulse. Then Start=0 → IDLE, Show=0.
- Seed=7'b1111110 (A=15, B=14, mul), DataIn=210 held with Go high for 20 cycles → exactly one Correct pulse.
- MAX_TRIES=3, Seed=7'b0101011, three Go presses with DataIn=0 → Tries 1,2,3, Wrong=1 after the first press, Done pulse after the third, Correct never asserts.
- Start dropped in WAIT_GO in the same cycle as a Go edge → IDLE next edge, no Correct/Done, Show=0.
- Reset asserted in CHECK → all outputs 0 immediately. Released with Start=1 → LATCH, Wrong=0, Tries=0.
